// File: rtl/lfsr_gen_pkg.sv
// Shared types and constants for the XNOR Fibonacci LFSR generator.
package lfsr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [18:0] LFSR_TAPS_19 = 19'h40023;

  // With XNOR feedback the all-ones word maps onto itself, so it must never be loaded.
  function automatic logic [31:0] lockup_word(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control, seed-load and output stream signals of the LFSR generator.
interface lfsr_gen_if #(
  parameter int WIDTH    = 19,
  parameter int OUT_BITS = 1
);
  logic                start;
  logic                stop;
  logic                one_shot;
  logic                load_valid;
  logic [WIDTH-1:0]    load_seed;
  logic                load_ready;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                period_tick;
  logic                lock_err;
  logic [WIDTH-1:0]    step_cnt;

  modport master (
    output start, stop, one_shot, load_valid, load_seed, out_ready,
    input  load_ready, out_valid, out_data, period_tick, lock_err, step_cnt
  );

  modport slave (
    input  start, stop, one_shot, load_valid, load_seed, out_ready,
    output load_ready, out_valid, out_data, period_tick, lock_err, step_cnt
  );
endinterface

// File: rtl/lfsr_gen_step.sv
// One combinational XNOR Fibonacci step plus a match flag against the start state.
module lfsr_gen_step #(
  parameter int               WIDTH = 19,
  parameter logic [WIDTH-1:0] TAPS  = 19'h40023
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_start,
  output logic [WIDTH-1:0] o_nxt,
  output logic             o_fb,
  output logic             o_hit
);
  assign o_fb  = ~^(i_cur & TAPS);
  assign o_nxt = {i_cur[WIDTH-2:0], o_fb};
  assign o_hit = (o_nxt == i_start);
endmodule

// File: rtl/lfsr_gen.sv
// LFSR stream generator: OUT_BITS steps per accepted transfer, seed load, one-shot/free-run.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH    = 19,
  parameter logic [WIDTH-1:0] TAPS     = LFSR_TAPS_19,
  parameter logic [WIDTH-1:0] SEED     = 19'h55555,
  parameter int               OUT_BITS = 1
) (
  input logic       clk,
  input logic       reset,
  lfsr_gen_if.slave bus
);
  localparam logic [31:0]      LOCK_WORD = lockup_word(WIDTH);
  localparam logic [WIDTH-1:0] LOCKUP    = LOCK_WORD[WIDTH-1:0];

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_lfsr, r_start, r_step_cnt;
  logic             r_one_shot, r_period_tick, r_lock_err;

  logic [WIDTH-1:0]    w_chain [OUT_BITS+1];
  logic [OUT_BITS-1:0] w_fb, w_hit;
  logic                w_xfer, w_load, w_lock, w_start_acc, w_period;
  logic [WIDTH-1:0]    w_seed;

  assign w_chain[0] = r_lfsr;

  // Every intermediate state is compared with start_reg so multi-step transfers still see the wrap.
  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_chain
    lfsr_gen_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .i_cur   (w_chain[gi]),
      .i_start (r_start),
      .o_nxt   (w_chain[gi+1]),
      .o_fb    (w_fb[gi]),
      .o_hit   (w_hit[gi])
    );
    assign bus.out_data[OUT_BITS-1-gi] = w_fb[gi];
  end

  assign w_xfer      = (r_state == ST_RUN) && bus.out_ready;
  assign w_load      = bus.load_valid && (r_state != ST_RUN);
  assign w_lock      = (bus.load_seed == LOCKUP);
  assign w_seed      = w_lock ? SEED : bus.load_seed;
  assign w_start_acc = (r_state != ST_RUN) && !w_load && bus.start && !bus.stop;
  assign w_period    = w_xfer && (|w_hit);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start_acc) w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.stop)                     w_state_next = ST_IDLE;
        else if (r_one_shot && w_period)  w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_lfsr        <= SEED;
      r_start       <= SEED;
      r_step_cnt    <= '0;
      r_one_shot    <= 1'b0;
      r_period_tick <= 1'b0;
      r_lock_err    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_period_tick <= w_period;
      r_lock_err    <= w_load && w_lock;
      if (w_start_acc) r_one_shot <= bus.one_shot;
      if (w_load) begin
        r_lfsr     <= w_seed;
        r_start    <= w_seed;
        r_step_cnt <= '0;
      end else if (w_start_acc) begin
        r_step_cnt <= '0;
      end else if (w_xfer) begin
        r_lfsr     <= w_chain[OUT_BITS];
        r_step_cnt <= r_step_cnt + WIDTH'(1);
      end
    end
  end

  assign bus.load_ready  = (r_state != ST_RUN);
  assign bus.out_valid   = (r_state == ST_RUN);
  assign bus.period_tick = r_period_tick;
  assign bus.lock_err    = r_lock_err;
  assign bus.step_cnt    = r_step_cnt;
endmodule

// File: tb/tb_lfsr_gen.sv
// Directed and randomized checks of lfsr_gen against an arithmetic reference model.
module tb_lfsr_gen;
  import lfsr_gen_pkg::*;

  localparam int          W    = 4;
  localparam logic [3:0]  SD   = 4'h5;
  localparam int unsigned TAPV = 32'hC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(W), .OUT_BITS(1)) ia ();
  lfsr_gen_if #(.WIDTH(W), .OUT_BITS(3)) ib ();

  lfsr_gen #(.WIDTH(W), .TAPS(LFSR_TAPS_4), .SEED(SD), .OUT_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  lfsr_gen #(.WIDTH(W), .TAPS(LFSR_TAPS_4), .SEED(SD), .OUT_BITS(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned mstep(input int unsigned v);
    int unsigned fb;
    fb = (^(v & TAPV)) ? 0 : 1;
    return ((v << 1) | fb) & ((32'd1 << W) - 1);
  endfunction

  function automatic int unsigned mwalk3(input int unsigned v);
    return mstep(mstep(mstep(v)));
  endfunction

  int unsigned ma, mb, mb_start, mb_cnt, v, s;
  bit mb_run, mb_tick, mb_lock, hit, xfer, rdy, lv, stp, sta;
  logic [3:0] seed;

  initial begin
    reset = 1'b0;
    {ia.start, ia.stop, ia.one_shot, ia.load_valid, ia.out_ready} = '0;
    {ib.start, ib.stop, ib.one_shot, ib.load_valid, ib.out_ready} = '0;
    ia.load_seed = '0;
    ib.load_seed = '0;
    tick(); tick();
    chk("rst_valid", 32'(ia.out_valid), 0);
    chk("rst_load_ready", 32'(ia.load_ready), 1);
    chk("rst_cnt", 32'(ia.step_cnt), 0);
    chk("rst_tick", 32'(ia.period_tick), 0);
    chk("rst_lock", 32'(ia.lock_err), 0);
    chk("rst_valid_b", 32'(ib.out_valid), 0);

    // First output after reset is the first step from SEED
    reset = 1'b1;
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("rst_first_data", 32'(ia.out_data), mstep(SD) & 1);
    chk("rst_first_valid", 32'(ia.out_valid), 1);

    // Mid-run reset returns everything to reset values
    ia.out_ready = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    chk("midrst_valid", 32'(ia.out_valid), 0);
    chk("midrst_cnt", 32'(ia.step_cnt), 0);
    chk("midrst_tick", 32'(ia.period_tick), 0);
    chk("midrst_load_ready", 32'(ia.load_ready), 1);
    reset = 1'b1; ia.out_ready = 1'b0;
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("midrst_restart_data", 32'(ia.out_data), mstep(SD) & 1);
    ia.stop = 1'b1; tick(); ia.stop = 1'b0;

    // Free-run full period from seed 0
    ia.load_valid = 1'b1; ia.load_seed = 4'h0; tick(); ia.load_valid = 1'b0;
    ia.one_shot = 1'b0; ia.start = 1'b1; tick(); ia.start = 1'b0;
    ma = 0; ia.out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      chk("free_data", 32'(ia.out_data), mstep(ma) & 1);
      chk("free_tick_early", 32'(ia.period_tick), 0);
      ma = mstep(ma);
      tick();
    end
    chk("free_tick", 32'(ia.period_tick), 1);
    chk("free_cnt", 32'(ia.step_cnt), 15);
    ia.stop = 1'b1; ia.out_ready = 1'b0; tick(); ia.stop = 1'b0;
    chk("free_stop_tick", 32'(ia.period_tick), 0);
    chk("free_stop_valid", 32'(ia.out_valid), 0);

    // One-shot: halts in DONE with register back at 0000
    ia.load_valid = 1'b1; ia.load_seed = 4'h0; tick(); ia.load_valid = 1'b0;
    ia.one_shot = 1'b1; ia.start = 1'b1; tick(); ia.start = 1'b0; ia.one_shot = 1'b0;
    ia.out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) tick();
    chk("oneshot_valid", 32'(ia.out_valid), 0);
    chk("oneshot_tick", 32'(ia.period_tick), 1);
    chk("oneshot_load_ready", 32'(ia.load_ready), 1);
    chk("oneshot_cnt", 32'(ia.step_cnt), 15);
    tick();
    chk("oneshot_tick_once", 32'(ia.period_tick), 0);
    chk("oneshot_hold_valid", 32'(ia.out_valid), 0);
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("oneshot_restart_cnt", 32'(ia.step_cnt), 0);
    chk("oneshot_restart_valid", 32'(ia.out_valid), 1);
    chk("oneshot_restart_data", 32'(ia.out_data), mstep(0) & 1);
    ia.stop = 1'b1; ia.out_ready = 1'b0; tick(); ia.stop = 1'b0;

    // All-ones load with simultaneous start: load wins, SEED substituted
    ia.load_valid = 1'b1; ia.load_seed = 4'hF; ia.start = 1'b1; tick();
    ia.load_valid = 1'b0; ia.start = 1'b0;
    chk("lock_pulse", 32'(ia.lock_err), 1);
    chk("lock_start_ignored", 32'(ia.out_valid), 0);
    tick();
    chk("lock_once", 32'(ia.lock_err), 0);
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk("lock_seed_data", 32'(ia.out_data), mstep(SD) & 1);
    ia.out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("lock_tick_seq", 32'(ia.period_tick), 32'(i == 15));
    end
    ia.stop = 1'b1; ia.out_ready = 1'b0; tick(); ia.stop = 1'b0;

    // Three steps per transfer: wrap seen on transfers 5, 10, 15
    ib.load_valid = 1'b1; ib.load_seed = 4'h0; tick(); ib.load_valid = 1'b0;
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    mb = 0; ib.out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      chk("ob3_data", 32'(ib.out_data), mwalk3(mb) & 7);
      mb = mwalk3(mb);
      tick();
      chk("ob3_tick", 32'(ib.period_tick), 32'(i % 5 == 0));
    end
    chk("ob3_cnt", 32'(ib.step_cnt), 15);
    ib.stop = 1'b1; ib.out_ready = 1'b0; tick(); ib.stop = 1'b0;

    // Randomized back-pressure, ignored loads in RUN, stop with transfer
    mb_run = 1'b0; mb_start = 0; mb_cnt = 15; mb_tick = 1'b0; mb_lock = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rdy  = 1'($urandom_range(0, 1));
      lv   = ($urandom_range(0, 7) == 0);
      seed = 4'($urandom_range(0, 15));
      stp  = mb_run && ($urandom_range(0, 15) == 0);
      sta  = !mb_run && ($urandom_range(0, 1) == 1);
      ib.out_ready = rdy; ib.load_valid = lv; ib.load_seed = seed;
      ib.stop = stp; ib.start = sta;
      chk("rnd_valid", 32'(ib.out_valid), 32'(mb_run));
      chk("rnd_load_ready", 32'(ib.load_ready), 32'(!mb_run));
      if (mb_run) chk("rnd_data", 32'(ib.out_data), mwalk3(mb) & 7);
      chk("rnd_cnt", 32'(ib.step_cnt), mb_cnt);
      chk("rnd_tick", 32'(ib.period_tick), 32'(mb_tick));
      chk("rnd_lock", 32'(ib.lock_err), 32'(mb_lock));
      xfer = mb_run && rdy;
      hit = 1'b0;
      v = mb;
      for (int k = 0; k < 3; k++) begin
        v = mstep(v);
        if (v == mb_start) hit = 1'b1;
      end
      mb_tick = xfer && hit;
      mb_lock = 1'b0;
      if (xfer) begin
        mb = v;
        mb_cnt = (mb_cnt + 1) & 15;
      end
      if (mb_run) begin
        if (stp) mb_run = 1'b0;
      end else if (lv) begin
        s = (seed == 4'hF) ? 32'(SD) : 32'(seed);
        mb = s; mb_start = s; mb_cnt = 0; mb_lock = (seed == 4'hF);
      end else if (sta) begin
        mb_run = 1'b1; mb_cnt = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
